axi4_lite_lstm_sequencer: RTL and testbench

- AXI4-Lite master that feeds an input sample stream through the LSTM layer block and returns each hidden-state result on an output stream.
- Per sample: write x to the LSTM input register, write the start bit, poll status until done, read the output register, then emit the result.
- Sits between the streaming datapath and the AXI4-Lite slave port of the LSTM layers block.

---
 rtl/lstm_regs_pkg.sv | 23 ++
 rtl/axi4_lite_single_master.sv | 116 +++++++++++
 rtl/axi4_lite_lstm_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_axi4_lite_lstm_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_regs_pkg.sv
// Register map, sequencer states and response codes shared by the LSTM AXI4-Lite sequencer.
package lstm_regs_pkg;

  localparam logic [31:0] REG_INPUT  = 32'h00;
  localparam logic [31:0] REG_CTRL   = 32'h04;
  localparam logic [31:0] REG_STATUS = 32'h08;
  localparam logic [31:0] REG_OUTPUT = 32'h0C;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned STATUS_DONE = 0;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StWrX,
    StWrGo,
    StPoll,
    StRdH,
    StOut
  } seq_state_e;

endpackage

// File: rtl/axi4_lite_single_master.sv
// Issues one AXI4-Lite write or read per req_i pulse; done_o pulses when the B or R beat lands.
module axi4_lite_single_master
  import lstm_regs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        resp_err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  logic        aw_valid_q, aw_valid_d;
  logic        w_valid_q, w_valid_d;
  logic        b_ready_q, b_ready_d;
  logic        ar_valid_q, ar_valid_d;
  logic        r_ready_q, r_ready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] araddr_q, araddr_d;
  logic        b_fire, r_fire;

  always_comb begin
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;

    if (aw_valid_q && awready_i) aw_valid_d = 1'b0;
    if (w_valid_q && wready_i)   w_valid_d  = 1'b0;
    // The response phase opens only once the last of AW/W has been taken.
    if ((aw_valid_q || w_valid_q) && !aw_valid_d && !w_valid_d) b_ready_d = 1'b1;

    b_fire = b_ready_q && bvalid_i;
    if (b_fire) b_ready_d = 1'b0;

    if (ar_valid_q && arready_i) begin
      ar_valid_d = 1'b0;
      r_ready_d  = 1'b1;
    end

    r_fire = r_ready_q && rvalid_i;
    if (r_fire) r_ready_d = 1'b0;

    if (req_i) begin
      if (we_i) begin
        aw_valid_d = 1'b1;
        w_valid_d  = 1'b1;
        awaddr_d   = addr_i;
        wdata_d    = wdata_i;
      end else begin
        ar_valid_d = 1'b1;
        araddr_d   = addr_i;
      end
    end

    done_o     = b_fire || r_fire;
    resp_err_o = (b_fire && (bresp_i != OKAY)) || (r_fire && (rresp_i != OKAY));
    rdata_o    = rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
    end else begin
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
    end
  end

  assign awaddr_o  = awaddr_q;
  assign awvalid_o = aw_valid_q;
  assign wdata_o   = wdata_q;
  assign wvalid_o  = w_valid_q;
  assign bready_o  = b_ready_q;
  assign araddr_o  = araddr_q;
  assign arvalid_o = ar_valid_q;
  assign rready_o  = r_ready_q;

endmodule

// File: rtl/axi4_lite_lstm_sequencer.sv
// Streams each sample through the LSTM slave: write x, start, poll done, read h, emit h.
module axi4_lite_lstm_sequencer
  import lstm_regs_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             err,
  output logic             busy,
  output logic [31:0]      awaddr,
  output logic [2:0]       awprot,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wvalid,
  input  logic             wready,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic [31:0]      araddr,
  output logic [2:0]       arprot,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready
);

  localparam int unsigned CntW   = $clog2(POLL_LIMIT + 1);
  localparam logic [31:0] CtrlGo = 32'(1) << CTRL_START;

  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [CntW-1:0]  poll_cnt_inc;
  logic             err_q, err_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [31:0]      x_ext;

  logic             bus_req, bus_we, bus_done, bus_err;
  logic [31:0]      bus_addr, bus_wdata, bus_rdata;

  always_comb begin
    x_ext            = '0;
    x_ext[WIDTH-1:0] = s_data;
  end

  // Each bus request is raised on the transition edge so the master's valids
  // come up in the first cycle of the new state.
  always_comb begin
    state_d      = state_q;
    poll_cnt_d   = poll_cnt_q;
    poll_cnt_inc = poll_cnt_q + CntW'(1);
    err_d        = err_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (s_valid && s_ready_q) begin
          bus_req   = 1'b1;
          bus_we    = 1'b1;
          bus_addr  = BASE_ADDR + REG_INPUT;
          bus_wdata = x_ext;
          state_d   = StWrX;
        end
      end
      StWrX: begin
        if (bus_done) begin
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            bus_req   = 1'b1;
            bus_we    = 1'b1;
            bus_addr  = BASE_ADDR + REG_CTRL;
            bus_wdata = CtrlGo;
            state_d   = StWrGo;
          end
        end
      end
      StWrGo: begin
        if (bus_done) begin
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            poll_cnt_d = '0;
            bus_req    = 1'b1;
            bus_addr   = BASE_ADDR + REG_STATUS;
            state_d    = StPoll;
          end
        end
      end
      StPoll: begin
        if (bus_done) begin
          poll_cnt_d = poll_cnt_inc;
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (bus_rdata[STATUS_DONE]) begin
            bus_req  = 1'b1;
            bus_addr = BASE_ADDR + REG_OUTPUT;
            state_d  = StRdH;
          end else if (poll_cnt_inc < CntW'(POLL_LIMIT)) begin
            bus_req  = 1'b1;
            bus_addr = BASE_ADDR + REG_STATUS;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRdH: begin
        if (bus_done) begin
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            m_data_d  = bus_rdata[WIDTH-1:0];
            m_valid_d = 1'b1;
            state_d   = StOut;
          end
        end
      end
      StOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // s_ready trails entry into IDLE by a cycle, which gives the gap after OUT.
    s_ready_d = (state_q == StIdle) && !(s_valid && s_ready_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  axi4_lite_single_master u_axi_master (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (bus_req),
    .we_i       (bus_we),
    .addr_i     (bus_addr),
    .wdata_i    (bus_wdata),
    .done_o     (bus_done),
    .resp_err_o (bus_err),
    .rdata_o    (bus_rdata),
    .awaddr_o   (awaddr),
    .awvalid_o  (awvalid),
    .awready_i  (awready),
    .wdata_o    (wdata),
    .wvalid_o   (wvalid),
    .wready_i   (wready),
    .bresp_i    (bresp),
    .bvalid_i   (bvalid),
    .bready_o   (bready),
    .araddr_o   (araddr),
    .arvalid_o  (arvalid),
    .arready_i  (arready),
    .rdata_i    (rdata),
    .rresp_i    (rresp),
    .rvalid_i   (rvalid),
    .rready_o   (rready)
  );

  assign awprot  = 3'b000;
  assign arprot  = 3'b000;
  assign wstrb   = 4'hF;
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_axi4_lite_lstm_sequencer.sv
// Directed bench: behavioural LSTM AXI4-Lite slave with configurable delays and responses.
module tb_axi4_lite_lstm_sequencer;

  logic        clk, rst;
  logic [31:0] s_data, m_data;
  logic        s_valid, s_ready, m_valid, m_ready, err, busy;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi4_lite_lstm_sequencer #(
    .WIDTH      (32),
    .POLL_LIMIT (8),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .err     (err),
    .busy    (busy),
    .awaddr  (awaddr),
    .awprot  (awprot),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arprot  (arprot),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observation.
  int          aw_delay, w_delay, b_delay, done_after;
  logic        ctrl_berr;
  logic [31:0] h_val;
  int          status_reads, out_reads, viol;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  logic        aw_acc, w_acc, ar_acc, b_fire, r_fire;
  int          aw_wait, w_wait, b_wait;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;

  task automatic setup(input int awd, input int wd, input int bd, input int da,
                       input logic berr, input logic [31:0] h);
    aw_delay = awd; w_delay = wd; b_delay = bd; done_after = da;
    ctrl_berr = berr; h_val = h;
    status_reads = 0; out_reads = 0; viol = 0;
    wr_addr.delete(); wr_data.delete();
  endtask

  // Slave: decides readies/valids at each negedge for the following posedge.
  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_acc = 0; w_acc = 0; ar_acc = 0; b_fire = 0; r_fire = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    aw_addr_l = 0; w_data_l = 0; ar_addr_l = 0;
    forever begin
      @(negedge clk);
      if (b_fire) begin bvalid = 0; b_fire = 0; aw_acc = 0; w_acc = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; ar_acc = 0; end
      // A valid still high after its accept edge is a protocol error.
      if (awready) begin aw_acc = 1; if (awvalid) viol++; end
      if (wready)  begin w_acc = 1;  if (wvalid) viol++; end
      if (arready) begin ar_acc = 1; if (arvalid) viol++; end
      awready = 0; wready = 0; arready = 0;
      if (rst) begin
        bvalid = 0; rvalid = 0; b_fire = 0; r_fire = 0;
        aw_acc = 0; w_acc = 0; ar_acc = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      end else begin
        if (awvalid && !aw_acc) begin
          if (aw_wait >= aw_delay) begin awready = 1; aw_addr_l = awaddr; aw_wait = 0; end
          else aw_wait++;
        end
        if (wvalid && !w_acc) begin
          if (w_wait >= w_delay) begin wready = 1; w_data_l = wdata; w_wait = 0; end
          else w_wait++;
        end
        if (aw_acc && w_acc && !bvalid) begin
          if (b_wait >= b_delay) begin
            bvalid = 1; b_wait = 0;
            bresp = (ctrl_berr && aw_addr_l == 32'h4) ? 2'b10 : 2'b00;
            wr_addr.push_back(aw_addr_l);
            wr_data.push_back(w_data_l);
          end else b_wait++;
        end
        if (bvalid && bready) b_fire = 1;
        if (arvalid && !ar_acc) begin arready = 1; ar_addr_l = araddr; end
        if (ar_acc && !rvalid) begin
          rvalid = 1; rresp = 2'b00;
          if (ar_addr_l == 32'h8) begin
            status_reads++;
            rdata = (done_after != 0 && status_reads >= done_after) ? 32'h1 : 32'h0;
          end else begin
            out_reads++;
            rdata = h_val;
          end
        end
        if (rvalid && rready) r_fire = 1;
      end
    end
  end

  // Offers one sample; returns cycles from the accept edge to m_valid (or to idle).
  task automatic send_sample(input logic [31:0] x, output int lat, output logic seen);
    int n;
    n = 0;
    @(negedge clk);
    s_data = x; s_valid = 1;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("s_ready_accept", {31'b0, s_ready}, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    s_valid = 0;
    while (!m_valid && busy && lat < 400) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    seen = m_valid;
    check_eq("seq_bounded", {31'b0, lat < 400}, 1);
  endtask

  task automatic accept_result();
    m_ready = 1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 0;
    check_eq("m_valid_drop", {31'b0, m_valid}, 0);
    check_eq("s_ready_gap", {31'b0, s_ready}, 0);
    @(negedge clk);
    check_eq("s_ready_back", {31'b0, s_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, bad, n;
    logic seen;
    rst = 1; s_valid = 0; s_data = 0; m_ready = 0;
    setup(0, 0, 0, 1, 0, 32'h0);
    #1;
    check_eq("rst_ctrl", {23'b0, awvalid, wvalid, bready, arvalid, rready, m_valid, s_ready,
                          err, busy}, 0);
    check_eq("rst_awaddr", awaddr, 0);
    check_eq("rst_araddr", araddr, 0);
    check_eq("rst_wdata", wdata, 0);
    check_eq("rst_m_data", m_data, 0);
    repeat (3) @(negedge clk);
    rst = 0;

    // Zero-wait slave, done on first poll.
    setup(0, 0, 0, 1, 0, 32'h0000ABCD);
    send_sample(32'h1234, lat, seen);
    check_eq("t1_latency", lat, 9);
    check_eq("t1_seen", {31'b0, seen}, 1);
    check_eq("t1_m_data", m_data, 32'hABCD);
    check_eq("t1_err", {31'b0, err}, 0);
    check_eq("t1_nwr", wr_addr.size(), 2);
    check_eq("t1_wr0_addr", wr_addr[0], 32'h0);
    check_eq("t1_wr0_data", wr_data[0], 32'h1234);
    check_eq("t1_wr1_addr", wr_addr[1], 32'h4);
    check_eq("t1_wr1_data", wr_data[1], 32'h1);
    check_eq("t1_status_reads", status_reads, 1);
    check_eq("t1_out_reads", out_reads, 1);
    accept_result();

    // AW accepted three cycles after W, B delayed five cycles.
    setup(3, 0, 5, 1, 0, 32'h00001111);
    send_sample(32'h55AA, lat, seen);
    check_eq("t2_seen", {31'b0, seen}, 1);
    check_eq("t2_m_data", m_data, 32'h1111);
    check_eq("t2_nwr", wr_addr.size(), 2);
    check_eq("t2_wr0_data", wr_data[0], 32'h55AA);
    check_eq("t2_wr1_addr", wr_addr[1], 32'h4);
    check_eq("t2_valid_drop", viol, 0);
    accept_result();

    // Done only on the eighth status read.
    setup(0, 0, 0, 8, 0, 32'h00002222);
    send_sample(32'h0003, lat, seen);
    check_eq("t3_status_reads", status_reads, 8);
    check_eq("t3_out_reads", out_reads, 1);
    check_eq("t3_m_data", m_data, 32'h2222);
    check_eq("t3_err", {31'b0, err}, 0);
    accept_result();

    // Backpressure on the result, then reset mid-POLL.
    setup(0, 0, 0, 1, 0, 32'h0000BEEF);
    send_sample(32'h0004, lat, seen);
    check_eq("t6_m_data", m_data, 32'hBEEF);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_data !== 32'hBEEF || m_valid !== 1'b1) bad++;
    end
    check_eq("t6_hold_stable", bad, 0);
    accept_result();
    setup(0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    s_data = 32'h42; s_valid = 1;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    s_valid = 0;
    repeat (9) @(negedge clk);
    check_eq("t6_in_poll", {31'b0, status_reads > 0 && status_reads < 8}, 1);
    check_eq("t6_busy_pre", {31'b0, busy}, 1);
    rst = 1;
    #1;
    check_eq("t6_rst_ctrl", {23'b0, awvalid, wvalid, bready, arvalid, rready, m_valid, s_ready,
                             err, busy}, 0);
    check_eq("t6_rst_m_data", m_data, 0);
    check_eq("t6_rst_araddr", araddr, 0);
    repeat (3) @(negedge clk);
    rst = 0;

    // Poll timeout: done never set.
    setup(0, 0, 0, 0, 0, 32'h0);
    send_sample(32'h0005, lat, seen);
    check_eq("t4_status_reads", status_reads, 8);
    check_eq("t4_out_reads", out_reads, 0);
    check_eq("t4_err", {31'b0, err}, 1);
    check_eq("t4_no_m_valid", {31'b0, seen}, 0);
    @(negedge clk);
    check_eq("t4_s_ready", {31'b0, s_ready}, 1);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // SLVERR on the CTRL write, then a clean sample with err staying set.
    setup(0, 0, 0, 1, 1, 32'h0);
    send_sample(32'h0006, lat, seen);
    check_eq("t5_err", {31'b0, err}, 1);
    check_eq("t5_no_reads", status_reads + out_reads, 0);
    check_eq("t5_nwr", wr_addr.size(), 2);
    check_eq("t5_no_m_valid", {31'b0, seen}, 0);
    check_eq("t5_idle", {31'b0, busy}, 0);
    setup(0, 0, 0, 1, 0, 32'h00007777);
    send_sample(32'h0007, lat, seen);
    check_eq("t5b_seen", {31'b0, seen}, 1);
    check_eq("t5b_m_data", m_data, 32'h7777);
    check_eq("t5b_err_sticky", {31'b0, err}, 1);
    accept_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
